ifc_bundle_tx: RTL and testbench
================================

IFC_BUNDLE_TX -- requirements
Module: ifc_bundle_tx

Interface
REQ-001: The block SHALL have no parameters; beat width is fixed at 8 bits and packet length at 5 beats.
REQ-002: CLK  input  1  single clock; all state updates on rising edge.
REQ-003: ASYNCRESET  input  1  asynchronous, active-high reset.
REQ-004: I_valid  input  1  upstream bundle valid.
REQ-005: I_ready  output  1  block can capture a bundle.
REQ-006: I_port0, I_port1, I_port3  input  5 each  5-bit bundle fields.
REQ-007: I_port10  input  3  3-bit bundle field.
REQ-008: I_port2  input  10  array of 5 x 2-bit elements; element k occupies bits [2k+1:2k].
REQ-009: I_port4, I_port5, I_port7, I_port8, I_port9  input  1 each  single-bit bundle fields.
REQ-010: O_valid  output  1  beat valid on the serial channel.
REQ-011: O_ready  input  1  downstream accepts the beat.
REQ-012: O_data  output  8  current beat.
REQ-013: O_last  output  1  high on beat 4 only.
REQ-014: O_par  output  1  even parity, equal to the XOR of all O_data bits.
REQ-015: O_count  output  8  count of completed packets.

Function
REQ-016: On capture, the block SHALL pack a 40-bit word P as follows: P[4:0]=port0, P[9:5]=port1, P[12:10]=port10, P[22:13]=port2, P[27:23]=port3, P[28]=port4, P[29]=port5, P[30]=port7, P[31]=port8, P[32]=port9, P[39:33]=0.
REQ-017: Beat k (k=0..4) SHALL carry O_data=P[8k+7:8k], LSB-first beat order.
REQ-018: The FSM SHALL have two states, IDLE and SEND; beat index is a 3-bit counter valid only in SEND.
REQ-019: In IDLE: I_ready=1, O_valid=0. In SEND: I_ready=0, O_valid=1.
REQ-020: A capture occurs when I_valid=1 and I_ready=1; it registers P, sets beat=0 and enters SEND on the same edge, so O_valid is high the following cycle (1-cycle latency).
REQ-021: A beat is transferred when O_valid=1 and O_ready=1; beat then increments.
REQ-022: While O_valid=1 and O_ready=0, O_data, O_last and O_par SHALL hold stable.
REQ-023: On transfer of beat 4, the FSM SHALL return to IDLE and O_count SHALL increment by 1, wrapping from 255 to 0.
REQ-024: After the last beat, I_ready SHALL rise the next cycle; packets are never overlapped, giving a minimum of 6 cycles per packet.
REQ-025: I_valid and the I_port* inputs SHALL be ignored while in SEND; changes to them SHALL NOT alter in-flight beats.
REQ-026: O_data, O_last and O_par SHALL be 0 whenever O_valid=0.

Reset
REQ-027: Asserting ASYNCRESET SHALL immediately force IDLE, beat=0, P=0, O_valid=0, O_data=0, O_last=0, O_par=0 and O_count=0, and SHALL hold I_ready=1 while ASYNCRESET is asserted.
REQ-028: A reset asserted mid-packet SHALL discard the remaining beats without incrementing O_count.
REQ-029: After ASYNCRESET deasserts, the first capture SHALL be possible on the first rising edge.

Verification
REQ-030: port0=5'h1F, port9=1, all other fields 0, O_ready=1 -> beats 0x1F, 0x00, 0x00, 0x00, 0x01 on consecutive cycles; O_par=1 then 0, 0, 0, 1; O_last only on the 5th beat; O_count 0->1.
REQ-031: port2 element 0 = 2'b11, all other fields 0 -> beat1=0x60 and all other beats 0x00.
REQ-032: Drive O_ready=0 for 3 cycles during beat 2 -> O_data held constant, no beat skipped or repeated; total packet takes 8 cycles.
REQ-033: Change I_port* and pulse I_valid during SEND -> beats unchanged; I_ready=0 throughout the packet; second packet captured only after return to IDLE.
REQ-034: Assert ASYNCRESET during beat 3 -> O_valid=0 immediately, O_count unchanged at 0, next packet starts cleanly at beat 0.
REQ-035: Send 256 packets back-to-back -> O_count wraps to 0, with I_ready high exactly one cycle between packets when I_valid is held high.

Source files
------------

// File: rtl/ifc_bundle_tx.sv
// Bundle-to-serial transmitter: captures a 40-bit field bundle and emits it
// as five 8-bit beats, LSB first, with even parity and a packet counter.
module ifc_bundle_tx (
   input  logic       CLK,
   input  logic       ASYNCRESET,
   input  logic       I_valid,
   output logic       I_ready,
   input  logic [4:0] I_port0,
   input  logic [4:0] I_port1,
   input  logic [9:0] I_port2,
   input  logic [4:0] I_port3,
   input  logic       I_port4,
   input  logic       I_port5,
   input  logic       I_port7,
   input  logic       I_port8,
   input  logic       I_port9,
   input  logic [2:0] I_port10,
   output logic       O_valid,
   input  logic       O_ready,
   output logic [7:0] O_data,
   output logic       O_last,
   output logic       O_par,
   output logic [7:0] O_count
);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   localparam logic [2:0] LAST_BEAT = 3'd4;

   state_t      state_q, state_d;
   logic [2:0]  beat_q, beat_d;
   logic [39:0] p_q, p_d;
   logic [7:0]  count_q, count_d;
   logic [39:0] pack;
   logic [7:0]  beat_sel;

   assign pack = {7'd0, I_port9, I_port8, I_port7, I_port5, I_port4,
                  I_port3, I_port2, I_port10, I_port1, I_port0};

   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         state_q <= IDLE;
         beat_q  <= 3'd0;
         p_q     <= 40'd0;
         count_q <= 8'd0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         p_q     <= p_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      p_d     = p_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if (I_valid) begin
               p_d     = pack;
               beat_d  = 3'd0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (O_ready) begin
               if (beat_q == LAST_BEAT) begin
                  state_d = IDLE;
                  beat_d  = 3'd0;
                  count_d = count_q + 8'd1;
               end else begin
                  beat_d = beat_q + 3'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      beat_sel = 8'd0;
      case (beat_q)
         3'd0:    beat_sel = p_q[7:0];
         3'd1:    beat_sel = p_q[15:8];
         3'd2:    beat_sel = p_q[23:16];
         3'd3:    beat_sel = p_q[31:24];
         3'd4:    beat_sel = p_q[39:32];
         default: beat_sel = 8'd0;
      endcase
   end

   // Outputs are gated to zero outside SEND so idle cycles present a clean bus.
   assign I_ready = (state_q == IDLE);
   assign O_valid = (state_q == SEND);
   assign O_data  = O_valid ? beat_sel : 8'd0;
   assign O_last  = O_valid && (beat_q == LAST_BEAT);
   assign O_par   = ^O_data;
   assign O_count = count_q;

endmodule

// File: tb/tb_ifc_bundle_tx.sv
// Directed bench for ifc_bundle_tx: fixed vectors with hand-computed beats.
module tb_ifc_bundle_tx;

   logic       CLK = 1'b0;
   logic       ASYNCRESET;
   logic       I_valid;
   logic       I_ready;
   logic [4:0] I_port0, I_port1, I_port3;
   logic [9:0] I_port2;
   logic       I_port4, I_port5, I_port7, I_port8, I_port9;
   logic [2:0] I_port10;
   logic       O_valid;
   logic       O_ready;
   logic [7:0] O_data;
   logic       O_last;
   logic       O_par;
   logic [7:0] O_count;

   int n_checks = 0;
   int n_err    = 0;

   ifc_bundle_tx dut (
      .CLK(CLK), .ASYNCRESET(ASYNCRESET),
      .I_valid(I_valid), .I_ready(I_ready),
      .I_port0(I_port0), .I_port1(I_port1), .I_port2(I_port2), .I_port3(I_port3),
      .I_port4(I_port4), .I_port5(I_port5), .I_port7(I_port7), .I_port8(I_port8),
      .I_port9(I_port9), .I_port10(I_port10),
      .O_valid(O_valid), .O_ready(O_ready), .O_data(O_data),
      .O_last(O_last), .O_par(O_par), .O_count(O_count)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_fields(input logic [4:0] p0, input logic [4:0] p1, input logic [2:0] p10,
                             input logic [9:0] p2, input logic [4:0] p3, input logic [4:0] bits98754);
      I_port0 = p0; I_port1 = p1; I_port10 = p10; I_port2 = p2; I_port3 = p3;
      {I_port9, I_port8, I_port7, I_port5, I_port4} = bits98754;
   endtask

   // Checks the beat currently presented; parity expectation is the XOR of the expected byte.
   task automatic beat_chk(input string tag, input logic [7:0] d, input logic last);
      chk({tag, " valid"}, {39'd0, O_valid}, 40'd1);
      chk({tag, " data"},  {32'd0, O_data}, {32'd0, d});
      chk({tag, " last"},  {39'd0, O_last}, {39'd0, last});
      chk({tag, " par"},   {39'd0, O_par},  {39'd0, ^d});
      chk({tag, " irdy"},  {39'd0, I_ready}, 40'd0);
   endtask

   task automatic idle_chk(input string tag, input logic [7:0] cnt);
      chk({tag, " valid"}, {39'd0, O_valid}, 40'd0);
      chk({tag, " data"},  {32'd0, O_data}, 40'd0);
      chk({tag, " last"},  {39'd0, O_last}, 40'd0);
      chk({tag, " par"},   {39'd0, O_par},  40'd0);
      chk({tag, " irdy"},  {39'd0, I_ready}, 40'd1);
      chk({tag, " count"}, {32'd0, O_count}, {32'd0, cnt});
   endtask

   initial begin
      int ir_cycles;
      logic seen255;

      ASYNCRESET = 1'b1;
      I_valid = 1'b0;
      O_ready = 1'b1;
      set_fields(5'd0, 5'd0, 3'd0, 10'd0, 5'd0, 5'd0);
      #12;
      idle_chk("reset", 8'd0);
      tick();
      ASYNCRESET = 1'b0;

      // Reset mid-packet at beat 3, then a clean restart.
      set_fields(5'd0, 5'd0, 3'd0, 10'h003, 5'd0, 5'd0);
      I_valid = 1'b1;
      tick();
      I_valid = 1'b0;
      beat_chk("rst b0", 8'h00, 1'b0);
      tick(); beat_chk("rst b1", 8'h60, 1'b0);
      tick(); beat_chk("rst b2", 8'h00, 1'b0);
      tick(); beat_chk("rst b3", 8'h00, 1'b0);
      ASYNCRESET = 1'b1;
      #1;
      idle_chk("rst async", 8'd0);
      tick();
      idle_chk("rst held", 8'd0);
      ASYNCRESET = 1'b0;
      set_fields(5'h1F, 5'd0, 3'd0, 10'd0, 5'd0, 5'b10000);
      I_valid = 1'b1;
      tick();
      I_valid = 1'b0;
      // First edge after release captures; this is the REQ-style 0x1F / port9 packet.
      beat_chk("p1 b0", 8'h1F, 1'b0);
      tick(); beat_chk("p1 b1", 8'h00, 1'b0);
      tick(); beat_chk("p1 b2", 8'h00, 1'b0);
      tick(); beat_chk("p1 b3", 8'h00, 1'b0);
      tick(); beat_chk("p1 b4", 8'h01, 1'b1);
      chk("p1 cnt before", {32'd0, O_count}, 40'd0);
      tick(); idle_chk("p1 done", 8'd1);

      // port2 element 0 lands in beat 1 bits 6:5.
      set_fields(5'd0, 5'd0, 3'd0, 10'h003, 5'd0, 5'd0);
      I_valid = 1'b1;
      tick();
      I_valid = 1'b0;
      beat_chk("p2 b0", 8'h00, 1'b0);
      tick(); beat_chk("p2 b1", 8'h60, 1'b0);
      tick(); beat_chk("p2 b2", 8'h00, 1'b0);
      tick(); beat_chk("p2 b3", 8'h00, 1'b0);
      tick(); beat_chk("p2 b4", 8'h00, 1'b1);
      tick(); idle_chk("p2 done", 8'd2);

      // Mixed fields, P = 0x1_59D4_B6AA, with 3 stall cycles on beat 2.
      set_fields(5'h0A, 5'h15, 3'b101, 10'h2A5, 5'h13, 5'b10101);
      I_valid = 1'b1;
      tick();
      I_valid = 1'b0;
      beat_chk("p3 b0", 8'hAA, 1'b0);
      tick(); beat_chk("p3 b1", 8'hB6, 1'b0);
      tick(); beat_chk("p3 b2", 8'hD4, 1'b0);
      O_ready = 1'b0;
      tick(); beat_chk("p3 stall1", 8'hD4, 1'b0);
      tick(); beat_chk("p3 stall2", 8'hD4, 1'b0);
      tick(); beat_chk("p3 stall3", 8'hD4, 1'b0);
      O_ready = 1'b1;
      tick(); beat_chk("p3 b3", 8'h59, 1'b0);
      tick(); beat_chk("p3 b4", 8'h01, 1'b1);
      tick(); idle_chk("p3 done", 8'd3);

      // Inputs churn during SEND; they must not disturb the in-flight packet.
      set_fields(5'h1F, 5'd0, 3'd0, 10'd0, 5'd0, 5'b10000);
      I_valid = 1'b1;
      tick();
      set_fields(5'h1F, 5'h1F, 3'h7, 10'h3FF, 5'h1F, 5'h1F);
      beat_chk("p4 b0", 8'h1F, 1'b0);
      I_valid = 1'b0;
      tick(); beat_chk("p4 b1", 8'h00, 1'b0);
      I_valid = 1'b1;
      tick(); beat_chk("p4 b2", 8'h00, 1'b0);
      I_valid = 1'b0;
      tick(); beat_chk("p4 b3", 8'h00, 1'b0);
      I_valid = 1'b1;
      tick(); beat_chk("p4 b4", 8'h01, 1'b1);
      tick(); idle_chk("p4 done", 8'd4);
      tick();
      I_valid = 1'b0;
      beat_chk("p5 b0", 8'hFF, 1'b0);
      tick(); beat_chk("p5 b1", 8'hFF, 1'b0);
      tick(); beat_chk("p5 b2", 8'hFF, 1'b0);
      tick(); beat_chk("p5 b3", 8'hFF, 1'b0);
      tick(); beat_chk("p5 b4", 8'h01, 1'b1);
      tick(); idle_chk("p5 done", 8'd5);

      // 256 back-to-back packets from a freshly reset counter: 6 cycles each.
      ASYNCRESET = 1'b1;
      #1;
      ASYNCRESET = 1'b0;
      idle_chk("wrap start", 8'd0);
      I_valid = 1'b1;
      ir_cycles = 0;
      seen255 = 1'b0;
      for (int c = 0; c < 256 * 6; c++) begin
         if (I_ready) ir_cycles++;
         if (O_count == 8'd255) seen255 = 1'b1;
         tick();
      end
      I_valid = 1'b0;
      chk("wrap irdy cycles", ir_cycles, 40'd256);
      chk("wrap saw 255", {39'd0, seen255}, 40'd1);
      idle_chk("wrap end", 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
